microsequencer: RTL

MICROSEQUENCER -- requirements
Module: microsequencer

---
 rtl/microsequencer_pkg.sv | 23 ++
 rtl/micro_return_stack.sv | 47 ++++
 rtl/microsequencer.sv | 92 +++++++++
 3 files changed

// File: rtl/microsequencer_pkg.sv
// Shared constants for the microsequencer: default address width,
// next-state operation encodings and status-condition indices.
package microsequencer_pkg;

    localparam int STATE_W = 10;

    typedef enum logic [2:0] {
        NS_INC  = 3'b000,
        NS_JMP  = 3'b001,
        NS_DEC  = 3'b010,
        NS_CJMP = 3'b011,
        NS_CALL = 3'b100,
        NS_RET  = 3'b101,
        NS_WAIT = 3'b110,
        NS_RST  = 3'b111
    } ns_op_e;

    localparam logic [1:0] COND_Z = 2'd0;
    localparam logic [1:0] COND_N = 2'd1;
    localparam logic [1:0] COND_C = 2'd2;
    localparam logic [1:0] COND_V = 2'd3;

endpackage

// File: rtl/micro_return_stack.sv
// LIFO return-address stack. Pushes when full and pops when empty are
// ignored here; the sequencer raises the sticky error flags for them.
module micro_return_stack #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int SP_W  = PTR_W + 1;

    logic [W-1:0]    mem [DEPTH];
    logic [SP_W-1:0] sp;
    logic [SP_W-1:0] top_idx;

    assign full    = (sp == SP_W'(DEPTH));
    assign empty   = (sp == '0);
    assign top_idx = sp - 1'b1;
    assign top     = mem[top_idx[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + 1'b1;
        end else if (pop && !empty) begin
            sp <= sp - 1'b1;
        end
    end

    // NOTE: entries above sp are never read, so the array carries no reset
    // and can map onto plain flops or a register file.
    always_ff @(posedge clk) begin
        if (!reset && push && !full) begin
            mem[sp[PTR_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/microsequencer.sv
// Microprogram sequencer: one address mux feeding the next_state register,
// with a return stack for CALL/RET and a moc-gated WAIT.
module microsequencer #(
    parameter int STATE_W     = microsequencer_pkg::STATE_W,
    parameter int STACK_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         ns_ctrl,
    input  logic [STATE_W-1:0] cr_addr,
    input  logic [STATE_W-1:0] decode_addr,
    input  logic [3:0]         cond_in,
    input  logic [1:0]         cond_sel,
    input  logic               cond_inv,
    input  logic               moc,
    input  logic               hold,
    output logic [STATE_W-1:0] next_state,
    output logic               waiting,
    output logic               stk_ovf,
    output logic               stk_unf
);

    import microsequencer_pkg::*;

    ns_op_e             op;
    logic               cond;
    logic [STATE_W-1:0] inc_addr;
    logic [STATE_W-1:0] mux_addr;
    logic [STATE_W-1:0] stk_top;
    logic               stk_full;
    logic               stk_empty;
    logic               do_push;
    logic               do_pop;

    assign op       = ns_op_e'(ns_ctrl);
    assign cond     = cond_in[cond_sel] ^ cond_inv;
    assign inc_addr = next_state + 1'b1;
    assign waiting  = (op == NS_WAIT) && !moc && !reset;
    assign do_push  = !reset && !hold && (op == NS_CALL);
    assign do_pop   = !reset && !hold && (op == NS_RET);

    micro_return_stack #(
        .W     (STATE_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (do_push),
        .pop       (do_pop),
        .push_data (inc_addr),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // NOTE: the default before the case keeps this block latch-free.
    always_comb begin
        mux_addr = inc_addr;
        unique case (op)
            NS_INC:  mux_addr = inc_addr;
            NS_JMP:  mux_addr = cr_addr;
            NS_DEC:  mux_addr = decode_addr;
            NS_CJMP: mux_addr = cond ? cr_addr : inc_addr;
            NS_CALL: mux_addr = cr_addr;
            NS_RET:  mux_addr = stk_empty ? '0 : stk_top;
            NS_WAIT: mux_addr = moc ? inc_addr : next_state;
            NS_RST:  mux_addr = '0;
            default: mux_addr = inc_addr;
        endcase
    end

    // NOTE: all state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            next_state <= '0;
        end else if (!hold) begin
            next_state <= mux_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stk_ovf <= 1'b0;
            stk_unf <= 1'b0;
        end else if (!hold) begin
            if (op == NS_CALL && stk_full) stk_ovf <= 1'b1;
            if (op == NS_RET && stk_empty) stk_unf <= 1'b1;
        end
    end

endmodule
